// File: rtl/link_hang_monitor_if.sv
// rtl/link_hang_monitor_if.sv - upstream NoC link signals observed by the hang monitor
interface link_hang_monitor_if;
  logic        tx_i;
  logic        cr_i;
  logic        eop_tx_i;
  logic [31:0] data_tx_i;

  modport master (output tx_i, output cr_i, output eop_tx_i, output data_tx_i);
  modport slave  (input tx_i, input cr_i, input eop_tx_i, input data_tx_i);
endinterface

// File: rtl/link_hang_monitor.sv
// rtl/link_hang_monitor.sv - passive link hang detector with packet header parser
// Optional CSV episode logging under macro HANG_MON_LOG_EN (default build has no file I/O).
module link_hang_monitor #(
  parameter logic [15:0] ADDRESS   = 16'b0,
  parameter string       PORT      = "",
  parameter int unsigned THRESHOLD = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  link_hang_monitor_if.slave  link,
  output logic                hang_o,
  output logic                hang_done_o,
  output logic [31:0]         hang_cycles_o,
  output logic [31:0]         hang_prod_o,
  output logic [31:0]         hang_cons_o,
  output logic [15:0]         hang_count_o,
  output logic [31:0]         pkt_count_o
);

  if (THRESHOLD < 1) begin : g_bad_threshold
    $error("link_hang_monitor %0s@%0h: THRESHOLD must be >= 1", PORT, ADDRESS);
  end

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_SIZE,
    ST_SERVICE,
    ST_PROD,
    ST_CONS,
    ST_PAYLOAD
  } state_t;

  localparam logic [31:0] ONSET_PREV = 32'(THRESHOLD - 1);

  state_t      state_q, state_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] cons_q, cons_d;
  logic [31:0] stall_q, stall_d;
  logic        hang_q, hang_d;
  logic        hang_done_q, hang_done_d;
  logic [31:0] hang_cycles_q, hang_cycles_d;
  logic [31:0] hang_prod_q, hang_prod_d;
  logic [31:0] hang_cons_q, hang_cons_d;
  logic [15:0] hang_count_q, hang_count_d;
  logic [31:0] pkt_count_q, pkt_count_d;

  logic accept;
  logic stall;
  logic onset;
  logic release_evt;

  always_comb begin
    accept      = link.tx_i && link.cr_i;
    stall       = link.tx_i && !link.cr_i;
    // Accept always wins over the stall that would have crossed the threshold.
    onset       = stall && !hang_q && (stall_q == ONSET_PREV);
    release_evt = accept && hang_q;
  end

  always_comb begin
    state_d       = state_q;
    prod_d        = prod_q;
    cons_d        = cons_q;
    stall_d       = stall_q;
    hang_d        = hang_q;
    hang_done_d   = 1'b0;
    hang_cycles_d = hang_cycles_q;
    hang_prod_d   = hang_prod_q;
    hang_cons_d   = hang_cons_q;
    hang_count_d  = hang_count_q;
    pkt_count_d   = pkt_count_q;

    if (accept) begin
      unique case (state_q)
        ST_HEADER: begin
          prod_d  = '0;
          cons_d  = '0;
          state_d = ST_SIZE;
        end
        ST_SIZE:    state_d = ST_SERVICE;
        ST_SERVICE: state_d = ST_PROD;
        ST_PROD: begin
          prod_d  = link.data_tx_i;
          state_d = ST_CONS;
        end
        ST_CONS: begin
          cons_d  = link.data_tx_i;
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: state_d = ST_PAYLOAD;
        default:    state_d = ST_HEADER;
      endcase
      if (link.eop_tx_i) begin
        state_d     = ST_HEADER;
        pkt_count_d = pkt_count_q + 32'd1;
      end
    end

    // tx_i low leaves the run length frozen so gapped stalls accumulate.
    if (accept) begin
      stall_d = '0;
    end else if (stall && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end

    if (onset) begin
      hang_d      = 1'b1;
      hang_prod_d = prod_q;
      hang_cons_d = cons_q;
    end

    if (release_evt) begin
      hang_d        = 1'b0;
      hang_done_d   = 1'b1;
      hang_cycles_d = stall_q;
      hang_count_d  = hang_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_HEADER;
      prod_q        <= '0;
      cons_q        <= '0;
      stall_q       <= '0;
      hang_q        <= 1'b0;
      hang_done_q   <= 1'b0;
      hang_cycles_q <= '0;
      hang_prod_q   <= '0;
      hang_cons_q   <= '0;
      hang_count_q  <= '0;
      pkt_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      prod_q        <= prod_d;
      cons_q        <= cons_d;
      stall_q       <= stall_d;
      hang_q        <= hang_d;
      hang_done_q   <= hang_done_d;
      hang_cycles_q <= hang_cycles_d;
      hang_prod_q   <= hang_prod_d;
      hang_cons_q   <= hang_cons_d;
      hang_count_q  <= hang_count_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  assign hang_o        = hang_q;
  assign hang_done_o   = hang_done_q;
  assign hang_cycles_o = hang_cycles_q;
  assign hang_prod_o   = hang_prod_q;
  assign hang_cons_o   = hang_cons_q;
  assign hang_count_o  = hang_count_q;
  assign pkt_count_o   = pkt_count_q;

`ifdef HANG_MON_LOG_EN
  time onset_t;

  initial begin
    $display("hm%0dx%0d-%0s: onset_time,rel_time,prod,cons,cycles", ADDRESS[15:8], ADDRESS[7:0], PORT);
  end

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      onset_t <= 0;
    end else begin
      if (onset) onset_t <= $time;
      if (release_evt)
        $display("hm%0dx%0d-%0s: %0d,%0d,%0d,%0d,%0d", ADDRESS[15:8], ADDRESS[7:0], PORT,
                 onset_t, $time, hang_prod_q, hang_cons_q, stall_q);
    end
  end
`endif

endmodule
